// File: rtl/fft_cfg_sequencer_pkg.sv
// Shared definitions for the FFT config sequencer: state encoding, tdata field
// offsets and the default settle/timeout constants also used by the FFT wrapper.
package fft_cfg_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SEND   = 2'd3
  } state_e;

  localparam int NFFT_LSB               = 0;
  localparam int FWD_INV_BIT            = 5;
  localparam int DEFAULT_SETTLE_CYCLES  = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Bits needed to hold a down-counter starting at n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_settle_timer.sv
// Loadable down-counter with a done flag at zero; used for both the settle
// window and the config-handshake timeout.
module cfg_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_r;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/fft_cfg_sequencer.sv
// Waits for settings to go quiet, gates the sample stream, drains the in-flight
// frame and issues one config beat. Optional handshake timeout: FFT_CFG_TIMEOUT_EN.
module fft_cfg_sequencer
  import fft_cfg_sequencer_pkg::*;
#(
  parameter int CFG_W          = 8,
  parameter int TDATA_W        = 16,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_change,
  input  logic [CFG_W-1:0]   cfg_in,
  input  logic               frame_busy,
  output logic [TDATA_W-1:0] m_cfg_tdata,
  output logic               m_cfg_tvalid,
  input  logic               m_cfg_tready,
  output logic               data_gate,
  output logic               cfg_applied,
  output logic               cfg_error
);

  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_e               state_r, next_state_s;
  logic                 settle_load_s, settle_dec_s, settle_done_s;
  logic                 handshake_s, timeout_s;
  logic                 tvalid_r, gate_r, applied_r, pending_r;
  logic [TDATA_W-1:0]   tdata_r;
  logic                 tvalid_s, gate_s, applied_s, pending_s;
  logic [TDATA_W-1:0]   tdata_s;

  assign handshake_s = (state_r == ST_SEND) && tvalid_r && m_cfg_tready;

  assign settle_load_s = (next_state_s == ST_SETTLE) && ((state_r != ST_SETTLE) || cfg_change);
  assign settle_dec_s  = (state_r == ST_SETTLE);

  cfg_settle_timer #(.W(SET_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load_s),
    .load_val (SETTLE_LOAD),
    .dec      (settle_dec_s),
    .done     (settle_done_s)
  );

`ifdef FFT_CFG_TIMEOUT_EN
  localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TIMEOUT_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic to_load_s, to_done_s, error_r;

  assign to_load_s = (next_state_s == ST_SEND) && (state_r != ST_SEND);

  cfg_settle_timer #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load_s),
    .load_val (TIMEOUT_LOAD),
    .dec      (state_r == ST_SEND),
    .done     (to_done_s)
  );

  // A handshake on the final waiting cycle still wins over the timeout.
  assign timeout_s = (state_r == ST_SEND) && !handshake_s && to_done_s;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r | timeout_s;
    end
  end

  assign cfg_error = error_r;
`else
  assign timeout_s = 1'b0;
  assign cfg_error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a change pulse always restarts the settle window except during SEND.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_change) next_state_s = ST_SETTLE;
        else            next_state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cfg_change)         next_state_s = ST_SETTLE;
        else if (settle_done_s) next_state_s = ST_DRAIN;
        else                    next_state_s = ST_SETTLE;
      end
      ST_DRAIN: begin
        if (cfg_change)       next_state_s = ST_SETTLE;
        else if (!frame_busy) next_state_s = ST_SEND;
        else                  next_state_s = ST_DRAIN;
      end
      ST_SEND: begin
        if (handshake_s)    next_state_s = (pending_r || cfg_change) ? ST_SETTLE : ST_IDLE;
        else if (timeout_s) next_state_s = ST_IDLE;
        else                next_state_s = ST_SEND;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    tvalid_s  = (next_state_s == ST_SEND);
    applied_s = handshake_s;
    tdata_s   = tdata_r;
    if ((state_r == ST_SETTLE) && (next_state_s == ST_DRAIN)) begin
      tdata_s = {TDATA_W{1'b0}};
      tdata_s[CFG_W-1:0] = cfg_in;
    end else begin
      tdata_s = tdata_r;
    end
    if (next_state_s != ST_SEND) begin
      pending_s = 1'b0;
    end else if (cfg_change) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
    case (next_state_s)
      ST_IDLE:   gate_s = 1'b1;
      ST_SETTLE: begin
        if (state_r == ST_DRAIN)     gate_s = 1'b0;
        else if (state_r == ST_SEND) gate_s = 1'b1;
        else                         gate_s = gate_r;
      end
      ST_DRAIN:  gate_s = 1'b0;
      ST_SEND:   gate_s = 1'b0;
      default:   gate_s = 1'b1;
    endcase
  end

  // Output registers; tdata only changes when a new config is latched at DRAIN entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_r  <= 1'b0;
      tdata_r   <= {TDATA_W{1'b0}};
      gate_r    <= 1'b1;
      applied_r <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      tvalid_r  <= tvalid_s;
      tdata_r   <= tdata_s;
      gate_r    <= gate_s;
      applied_r <= applied_s;
      pending_r <= pending_s;
    end
  end

  assign m_cfg_tvalid = tvalid_r;
  assign m_cfg_tdata  = tdata_r;
  assign data_gate    = gate_r;
  assign cfg_applied  = applied_r;

endmodule

// File: tb/tb_fft_cfg_sequencer.sv
// Directed self-checking bench for fft_cfg_sequencer (SETTLE_CYCLES=16, TIMEOUT_CYCLES=32).
module tb_fft_cfg_sequencer;

  localparam int CFG_W   = 8;
  localparam int TDATA_W = 16;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 32;
  localparam int LAT     = SETTLE + 1;  // ticks from the pulse-sampling edge to tvalid

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_change;
  logic [CFG_W-1:0]   cfg_in;
  logic               frame_busy;
  logic [TDATA_W-1:0] m_cfg_tdata;
  logic               m_cfg_tvalid;
  logic               m_cfg_tready;
  logic               data_gate;
  logic               cfg_applied;
  logic               cfg_error;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int pulses = 0;

  fft_cfg_sequencer #(
    .CFG_W(CFG_W), .TDATA_W(TDATA_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_change(cfg_change), .cfg_in(cfg_in),
    .frame_busy(frame_busy), .m_cfg_tdata(m_cfg_tdata), .m_cfg_tvalid(m_cfg_tvalid),
    .m_cfg_tready(m_cfg_tready), .data_gate(data_gate), .cfg_applied(cfg_applied),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_cfg_tvalid && m_cfg_tready) beats <= beats + 1;
    if (cfg_applied) pulses <= pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_change(input logic [CFG_W-1:0] v);
    cfg_in = v;
    cfg_change = 1'b1;
    tick();
    cfg_change = 1'b0;
  endtask

  task automatic wait_tvalid(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_cfg_tvalid && n < limit);
    if (!m_cfg_tvalid) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cfg_change = 1'b0; cfg_in = 8'h00; frame_busy = 1'b0; m_cfg_tready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_cfg_tvalid !== 1'b0 || m_cfg_tdata !== 16'h0000 || data_gate !== 1'b1 ||
        cfg_applied !== 1'b0 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tvalid=%b tdata=%h gate=%b applied=%b err=%b, want 0 0000 1 0 0",
               m_cfg_tvalid, m_cfg_tdata, data_gate, cfg_applied, cfg_error);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n, b0, p0;
    b0 = beats; p0 = pulses;
    m_cfg_tready = 1'b1;
    pulse_change(8'h0A);
    checks++;
    if (data_gate !== 1'b1) begin
      errors++; $display("FAIL single_gate_settle: got %b want 1", data_gate);
    end
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL single_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if (m_cfg_tdata !== 16'h000A || data_gate !== 1'b0) begin
      errors++; $display("FAIL single_beat: tdata=%h gate=%b want 000a 0", m_cfg_tdata, data_gate);
    end
    tick();
    checks++;
    if (m_cfg_tvalid !== 1'b0 || cfg_applied !== 1'b1 || data_gate !== 1'b1) begin
      errors++;
      $display("FAIL single_handshake: tvalid=%b applied=%b gate=%b want 0 1 1",
               m_cfg_tvalid, cfg_applied, data_gate);
    end
    tick();
    checks++;
    if (cfg_applied !== 1'b0) begin
      errors++; $display("FAIL single_applied_width: got %b want 0", cfg_applied);
    end
    repeat (10) tick();
    checks++;
    if (beats - b0 !== 1 || pulses - p0 !== 1) begin
      errors++; $display("FAIL single_counts: beats=%0d pulses=%0d want 1 1", beats - b0, pulses - p0);
    end
    checks++;
    if (cfg_error !== 1'b0) begin
      errors++; $display("FAIL single_no_error: got %b want 0", cfg_error);
    end
  endtask

  task automatic test_back_to_back();
    int n, b0;
    logic [CFG_W-1:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    b0 = beats;
    m_cfg_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pulse_change(vals[i]);
      if (i < 3) repeat (4) tick();
    end
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL b2b_latency: got %0d want %0d", n, LAT);
    end
    checks++;
    if (m_cfg_tdata !== 16'h0044) begin
      errors++; $display("FAIL b2b_tdata: got %h want 0044", m_cfg_tdata);
    end
    repeat (10) tick();
    checks++;
    if (beats - b0 !== 1) begin
      errors++; $display("FAIL b2b_beats: got %0d want 1", beats - b0);
    end
  endtask

  task automatic test_drain();
    logic ok;
    m_cfg_tready = 1'b1;
    frame_busy = 1'b1;
    pulse_change(8'h5A);
    repeat (SETTLE) tick();
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (data_gate !== 1'b0 || m_cfg_tvalid !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL drain_hold: gate/tvalid changed while busy, last gate=%b tvalid=%b want 0 0",
                         data_gate, m_cfg_tvalid);
    end
    frame_busy = 1'b0;
    tick();
    checks++;
    if (m_cfg_tvalid !== 1'b1 || m_cfg_tdata !== 16'h005A || data_gate !== 1'b0) begin
      errors++; $display("FAIL drain_release: tvalid=%b tdata=%h gate=%b want 1 005a 0",
                         m_cfg_tvalid, m_cfg_tdata, data_gate);
    end
    repeat (5) tick();
  endtask

  task automatic test_backpressure();
    int n, b0;
    logic ok;
    b0 = beats;
    m_cfg_tready = 1'b0;
    pulse_change(8'h55);
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL bp_latency: got %0d want %0d", n, LAT);
    end
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        cfg_in = 8'h66; cfg_change = 1'b1;
      end
      tick();
      cfg_change = 1'b0;
      if (m_cfg_tvalid !== 1'b1 || m_cfg_tdata !== 16'h0055) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL bp_stable: tvalid=%b tdata=%h want 1 0055", m_cfg_tvalid, m_cfg_tdata);
    end
    m_cfg_tready = 1'b1;
    tick();
    checks++;
    if (m_cfg_tvalid !== 1'b0 || cfg_applied !== 1'b1) begin
      errors++; $display("FAIL bp_handshake: tvalid=%b applied=%b want 0 1", m_cfg_tvalid, cfg_applied);
    end
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT || m_cfg_tdata !== 16'h0066) begin
      errors++; $display("FAIL bp_second_beat: ticks=%0d tdata=%h want %0d 0066", n, m_cfg_tdata, LAT);
    end
    repeat (5) tick();
    checks++;
    if (beats - b0 !== 2) begin
      errors++; $display("FAIL bp_beats: got %0d want 2", beats - b0);
    end
  endtask

  task automatic test_async_reset();
    int n, b0;
    logic ok;
    b0 = beats;
    m_cfg_tready = 1'b0;
    pulse_change(8'h77);
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL rst_pre_latency: got %0d want %0d", n, LAT);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_cfg_tvalid !== 1'b0 || data_gate !== 1'b1 || m_cfg_tdata !== 16'h0000) begin
      errors++; $display("FAIL rst_async: tvalid=%b gate=%b tdata=%h want 0 1 0000",
                         m_cfg_tvalid, data_gate, m_cfg_tdata);
    end
    tick(); tick();
    rst_n = 1'b1;
    m_cfg_tready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_cfg_tvalid !== 1'b0 || data_gate !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1 || beats - b0 !== 0) begin
      errors++; $display("FAIL rst_idle_after: tvalid=%b gate=%b beats=%0d want 0 1 0",
                         m_cfg_tvalid, data_gate, beats - b0);
    end
  endtask

`ifdef FFT_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int n, p0;
    p0 = pulses;
    m_cfg_tready = 1'b0;
    pulse_change(8'h3C);
    wait_tvalid(40, n);
    checks++;
    if (n !== LAT) begin
      errors++; $display("FAIL to_latency: got %0d want %0d", n, LAT);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (m_cfg_tvalid && n < 100);
    checks++;
    if (n !== TIMEOUT) begin
      errors++; $display("FAIL to_drop_cycle: got %0d want %0d", n, TIMEOUT);
    end
    checks++;
    if (cfg_error !== 1'b1 || data_gate !== 1'b1) begin
      errors++; $display("FAIL to_flags: err=%b gate=%b want 1 1", cfg_error, data_gate);
    end
    repeat (5) tick();
    checks++;
    if (cfg_error !== 1'b1 || pulses - p0 !== 0) begin
      errors++; $display("FAIL to_sticky: err=%b pulses=%0d want 1 0", cfg_error, pulses - p0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_error !== 1'b0) begin
      errors++; $display("FAIL to_reset_clear: got %b want 0", cfg_error);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drain();
    test_backpressure();
    test_async_reset();
`ifdef FFT_CFG_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
